// File: rtl/pu_wb_buf.sv
// Writeback retire buffer: queues committed results in order, drains them one per
// accepted cycle to a shared GPR/HI/LO write port, forwards to ID, and raises precise exceptions.
module pu_wb_buf #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter int GPR_AW = 5,
  parameter int EXP_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_flush,
  output logic              wb_busy,
  input  logic              in_en,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_rd_en,
  input  logic [GPR_AW-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  input  logic              in_hi_en,
  input  logic [DATA_W-1:0] in_hi_data,
  input  logic              in_lo_en,
  input  logic [DATA_W-1:0] in_lo_data,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              rf_wr_valid,
  input  logic              rf_wr_ready,
  output logic [PC_W-1:0]   rf_pc,
  output logic              rf_rd_en,
  output logic [GPR_AW-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_hi_en,
  output logic [DATA_W-1:0] rf_hi_data,
  output logic              rf_lo_en,
  output logic [DATA_W-1:0] rf_lo_data,
  output logic              exp_valid,
  output logic [PC_W-1:0]   exp_pc,
  output logic [EXP_W-1:0]  exp_code,
  input  logic [GPR_AW-1:0] fwd_addr,
  output logic              fwd_rd_hit,
  output logic [DATA_W-1:0] fwd_rd_data,
  output logic              fwd_hi_hit,
  output logic [DATA_W-1:0] fwd_hi_data,
  output logic              fwd_lo_hit,
  output logic [DATA_W-1:0] fwd_lo_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              rd_en;
    logic [GPR_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              hi_en;
    logic [DATA_W-1:0] hi_data;
    logic              lo_en;
    logic [DATA_W-1:0] lo_data;
    logic [EXP_W-1:0]  exp;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head_e;
  entry_t            in_e;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              not_empty;
  logic              full;
  logic              squash;
  logic              has_work;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_e    = mem[head];
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign squash    = not_empty && (head_e.exp != '0);
  assign has_work  = in_rd_en || in_hi_en || in_lo_en || (in_exp != '0);
  assign push      = in_en && !wb_flush && !full && !squash && has_work;

  assign wb_busy     = !rst && full;
  assign rf_wr_valid = !rst && not_empty && !squash;
  assign pop         = rf_wr_valid && rf_wr_ready;

  always_comb begin
    in_e         = '0;
    in_e.pc      = in_pc;
    // Writes to r0 are architecturally void; drop the enable so neither rf nor fwd sees it.
    in_e.rd_en   = in_rd_en && (in_rd_addr != '0);
    in_e.rd_addr = in_rd_addr;
    in_e.rd_data = in_rd_data;
    in_e.hi_en   = in_hi_en;
    in_e.hi_data = in_hi_data;
    in_e.lo_en   = in_lo_en;
    in_e.lo_data = in_lo_data;
    in_e.exp     = in_exp;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      exp_valid <= 1'b0;
      exp_pc    <= '0;
      exp_code  <= '0;
    end else begin
      exp_valid <= squash;
      exp_pc    <= squash ? head_e.pc : '0;
      exp_code  <= squash ? head_e.exp : '0;
      if (squash) begin
        // Excepting head kills itself and every younger entry in one edge.
        count <= '0;
        head  <= tail;
      end else begin
        if (push) begin
          tail <= ptr_inc(tail);
        end
        if (pop) begin
          head <= ptr_inc(head);
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    rf_pc      = '0;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_rd_data = '0;
    rf_hi_en   = 1'b0;
    rf_hi_data = '0;
    rf_lo_en   = 1'b0;
    rf_lo_data = '0;
    if (rf_wr_valid) begin
      rf_pc      = head_e.pc;
      rf_rd_en   = head_e.rd_en;
      rf_rd_addr = head_e.rd_addr;
      rf_rd_data = head_e.rd_data;
      rf_hi_en   = head_e.hi_en;
      rf_hi_data = head_e.hi_data;
      rf_lo_en   = head_e.lo_en;
      rf_lo_data = head_e.lo_data;
    end
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_rd_hit  = 1'b0;
    fwd_rd_data = '0;
    fwd_hi_hit  = 1'b0;
    fwd_hi_data = '0;
    fwd_lo_hit  = 1'b0;
    fwd_lo_data = '0;
    idx         = head;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && (CNT_W'(i) < count)) begin
        if (mem[idx].rd_en && (mem[idx].exp == '0) && (fwd_addr != '0) &&
            (mem[idx].rd_addr == fwd_addr)) begin
          fwd_rd_hit  = 1'b1;
          fwd_rd_data = mem[idx].rd_data;
        end
        if (mem[idx].hi_en) begin
          fwd_hi_hit  = 1'b1;
          fwd_hi_data = mem[idx].hi_data;
        end
        if (mem[idx].lo_en) begin
          fwd_lo_hit  = 1'b1;
          fwd_lo_data = mem[idx].lo_data;
        end
      end
      idx = ptr_inc(idx);
    end
  end

endmodule

// File: tb/tb_pu_wb_buf.sv
// Bench for pu_wb_buf: directed vector table, hand sequences for reset/wrap, and a
// randomized run against a shift-queue reference model on DEPTH=4 and DEPTH=3 instances.
module tb_pu_wb_buf;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        flush;
    logic [29:0] pc;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        hi_en;
    logic [31:0] hi_data;
    logic        lo_en;
    logic [31:0] lo_data;
    logic [3:0]  exp;
    logic        rdy;
    logic [4:0]  fwd;
  } stim_t;

  typedef struct packed {
    logic        busy;
    logic        valid;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        hi_en;
    logic        fhit;
    logic [31:0] fdata;
    logic        ev;
    logic [29:0] epc;
    logic [3:0]  ecode;
  } xp_t;

  typedef struct packed {
    stim_t s;
    xp_t   x;
  } vec_t;

  typedef struct packed {
    logic        busy;
    logic        valid;
    logic [29:0] pc;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        hi_en;
    logic [31:0] hi_data;
    logic        lo_en;
    logic [31:0] lo_data;
    logic        ev;
    logic [29:0] epc;
    logic [3:0]  ecode;
    logic        fhit;
    logic [31:0] fdata;
    logic        fhi;
    logic [31:0] fhid;
    logic        flo;
    logic [31:0] flod;
  } obs_t;

  typedef struct packed {
    logic [29:0] pc;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        hi_en;
    logic [31:0] hi_data;
    logic        lo_en;
    logic [31:0] lo_data;
    logic [3:0]  exp;
  } ment_t;

  // Oldest entry always at e[0]; the buffer is a plain shifting list.
  typedef struct packed {
    ment_t [7:0] e;
    logic [3:0]  cnt;
    logic [3:0]  depth;
    logic        ev;
    logic [29:0] epc;
    logic [3:0]  ecode;
  } mstate_t;

  logic clk = 1'b0;
  logic rst, wb_flush, in_en, in_rd_en, in_hi_en, in_lo_en, rf_wr_ready;
  logic [29:0] in_pc;
  logic [4:0]  in_rd_addr, fwd_addr;
  logic [31:0] in_rd_data, in_hi_data, in_lo_data;
  logic [3:0]  in_exp;

  logic busy4, valid4, rden4, hien4, loen4, ev4, fh4, fhh4, flh4;
  logic [29:0] pc4, epc4;
  logic [4:0]  addr4;
  logic [31:0] data4, hid4, lod4, fd4, fhd4, fld4;
  logic [3:0]  ecode4;
  logic busy3, valid3, rden3, hien3, loen3, ev3, fh3, fhh3, flh3;
  logic [29:0] pc3, epc3;
  logic [4:0]  addr3;
  logic [31:0] data3, hid3, lod3, fd3, fhd3, fld3;
  logic [3:0]  ecode3;

  obs_t o4, o3;
  xp_t  g4;
  assign o4 = {busy4, valid4, pc4, rden4, addr4, data4, hien4, hid4, loen4, lod4,
               ev4, epc4, ecode4, fh4, fd4, fhh4, fhd4, flh4, fld4};
  assign o3 = {busy3, valid3, pc3, rden3, addr3, data3, hien3, hid3, loen3, lod3,
               ev3, epc3, ecode3, fh3, fd3, fhh3, fhd3, flh3, fld3};
  assign g4 = {busy4, valid4, rden4, addr4, data4, hien4, fh4, fd4, ev4, epc4, ecode4};

  always #5 clk = ~clk;

  pu_wb_buf #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .wb_flush(wb_flush), .wb_busy(busy4),
    .in_en(in_en), .in_pc(in_pc), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data), .in_hi_en(in_hi_en), .in_hi_data(in_hi_data),
    .in_lo_en(in_lo_en), .in_lo_data(in_lo_data), .in_exp(in_exp),
    .rf_wr_valid(valid4), .rf_wr_ready(rf_wr_ready), .rf_pc(pc4), .rf_rd_en(rden4),
    .rf_rd_addr(addr4), .rf_rd_data(data4), .rf_hi_en(hien4), .rf_hi_data(hid4),
    .rf_lo_en(loen4), .rf_lo_data(lod4), .exp_valid(ev4), .exp_pc(epc4),
    .exp_code(ecode4), .fwd_addr(fwd_addr), .fwd_rd_hit(fh4), .fwd_rd_data(fd4),
    .fwd_hi_hit(fhh4), .fwd_hi_data(fhd4), .fwd_lo_hit(flh4), .fwd_lo_data(fld4)
  );

  pu_wb_buf #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .wb_flush(wb_flush), .wb_busy(busy3),
    .in_en(in_en), .in_pc(in_pc), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data), .in_hi_en(in_hi_en), .in_hi_data(in_hi_data),
    .in_lo_en(in_lo_en), .in_lo_data(in_lo_data), .in_exp(in_exp),
    .rf_wr_valid(valid3), .rf_wr_ready(rf_wr_ready), .rf_pc(pc3), .rf_rd_en(rden3),
    .rf_rd_addr(addr3), .rf_rd_data(data3), .rf_hi_en(hien3), .rf_hi_data(hid3),
    .rf_lo_en(loen3), .rf_lo_data(lod3), .exp_valid(ev3), .exp_pc(epc3),
    .exp_code(ecode3), .fwd_addr(fwd_addr), .fwd_rd_hit(fh3), .fwd_rd_data(fd3),
    .fwd_hi_hit(fhh3), .fwd_hi_data(fhd3), .fwd_lo_hit(flh3), .fwd_lo_data(fld3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
    end
  endtask

  task automatic drive(input stim_t t);
    rst = t.rst; in_en = t.en; wb_flush = t.flush; in_pc = t.pc;
    in_rd_en = t.rd_en; in_rd_addr = t.rd_addr; in_rd_data = t.rd_data;
    in_hi_en = t.hi_en; in_hi_data = t.hi_data; in_lo_en = t.lo_en;
    in_lo_data = t.lo_data; in_exp = t.exp; rf_wr_ready = t.rdy; fwd_addr = t.fwd;
  endtask

  function automatic vec_t v(input int en, flush, rdy, pc, rde, addr, data, hilo, ex, fwd,
                             input int xb, xv, xrde, xaddr, xdata, xhi, xfh, xfd,
                             input int xev, xepc, xec);
    vec_t r;
    r = '0;
    r.s.en = 1'(en); r.s.flush = 1'(flush); r.s.rdy = 1'(rdy); r.s.pc = 30'(pc);
    r.s.rd_en = 1'(rde); r.s.rd_addr = 5'(addr); r.s.rd_data = 32'(data);
    r.s.hi_en = 1'(hilo); r.s.hi_data = 32'h1111; r.s.lo_en = 1'(hilo);
    r.s.lo_data = 32'h2222; r.s.exp = 4'(ex); r.s.fwd = 5'(fwd);
    r.x = {1'(xb), 1'(xv), 1'(xrde), 5'(xaddr), 32'(xdata), 1'(xhi), 1'(xfh),
           32'(xfd), 1'(xev), 30'(xepc), 4'(xec)};
    return r;
  endfunction

  function automatic obs_t m_obs(input mstate_t s, input stim_t t);
    obs_t o;
    o = '0;
    o.ev = s.ev; o.epc = s.epc; o.ecode = s.ecode;
    if (!t.rst) begin
      o.busy = (s.cnt == s.depth);
      if (s.cnt != 0 && s.e[0].exp == 0) begin
        o.valid = 1'b1; o.pc = s.e[0].pc; o.rd_en = s.e[0].rd_en;
        o.rd_addr = s.e[0].rd_addr; o.rd_data = s.e[0].rd_data;
        o.hi_en = s.e[0].hi_en; o.hi_data = s.e[0].hi_data;
        o.lo_en = s.e[0].lo_en; o.lo_data = s.e[0].lo_data;
      end
      for (int i = 0; i < 8; i++) begin
        if (i < int'(s.cnt)) begin
          if (s.e[i].rd_en && s.e[i].exp == 0 && t.fwd != 0 && s.e[i].rd_addr == t.fwd) begin
            o.fhit = 1'b1; o.fdata = s.e[i].rd_data;
          end
          if (s.e[i].hi_en) begin o.fhi = 1'b1; o.fhid = s.e[i].hi_data; end
          if (s.e[i].lo_en) begin o.flo = 1'b1; o.flod = s.e[i].lo_data; end
        end
      end
    end
    return o;
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input stim_t t);
    mstate_t n;
    ment_t   e;
    logic    pop, push;
    n = s;
    n.ev = 1'b0; n.epc = '0; n.ecode = '0;
    if (t.rst) begin
      n.cnt = '0;
      return n;
    end
    if (s.cnt != 0 && s.e[0].exp != 0) begin
      n.ev = 1'b1; n.epc = s.e[0].pc; n.ecode = s.e[0].exp; n.cnt = '0;
      return n;
    end
    pop  = (s.cnt != 0) && t.rdy;
    push = t.en && !t.flush && (s.cnt != s.depth) &&
           (t.rd_en || t.hi_en || t.lo_en || t.exp != 0);
    if (pop) begin
      for (int i = 0; i < 7; i++) n.e[i] = n.e[i+1];
      n.cnt = n.cnt - 4'd1;
    end
    if (push) begin
      e.pc = t.pc; e.rd_en = t.rd_en && (t.rd_addr != 0); e.rd_addr = t.rd_addr;
      e.rd_data = t.rd_data; e.hi_en = t.hi_en; e.hi_data = t.hi_data;
      e.lo_en = t.lo_en; e.lo_data = t.lo_data; e.exp = t.exp;
      n.e[n.cnt[2:0]] = e;
      n.cnt = n.cnt + 4'd1;
    end
    return n;
  endfunction

  function automatic stim_t rnd();
    stim_t t;
    t = '0;
    t.rst     = ($urandom_range(0, 99) == 0);
    t.en      = ($urandom_range(0, 9) < 7);
    t.flush   = ($urandom_range(0, 9) == 0);
    t.pc      = 30'($urandom);
    t.rd_en   = ($urandom_range(0, 1) == 1);
    t.rd_addr = 5'($urandom_range(0, 7));
    t.rd_data = $urandom;
    t.hi_en   = ($urandom_range(0, 4) == 0);
    t.hi_data = $urandom;
    t.lo_en   = ($urandom_range(0, 4) == 0);
    t.lo_data = $urandom;
    t.exp     = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    t.rdy     = ($urandom_range(0, 9) < 6);
    t.fwd     = 5'($urandom_range(0, 7));
    return t;
  endfunction

  vec_t    tbl [32];
  stim_t   t;
  mstate_t m4, m3;
  int      k, got;

  initial begin
    //         en fl rdy pc     rde ad data   hl ex fw | b v rde ad data  hi fh fdata  ev epc   ec
    tbl[0]  = v(1, 0, 1, 'h1,   1, 5, 'h1234, 0, 0, 5,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[1]  = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 5,   0, 1, 1, 5, 'h1234, 0, 1, 'h1234, 0, 0,     0);
    tbl[2]  = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 5,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[3]  = v(1, 0, 0, 'h2,   1, 7, 'hA,    0, 0, 7,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[4]  = v(1, 0, 0, 'h3,   1, 7, 'hB,    0, 0, 7,   0, 1, 1, 7, 'hA,    0, 1, 'hA,    0, 0,     0);
    tbl[5]  = v(1, 0, 0, 'h4,   1, 0, 'h55,   0, 0, 7,   0, 1, 1, 7, 'hA,    0, 1, 'hB,    0, 0,     0);
    tbl[6]  = v(0, 0, 0, 0,     0, 0, 0,      0, 0, 0,   0, 1, 1, 7, 'hA,    0, 0, 0,      0, 0,     0);
    tbl[7]  = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 7,   0, 1, 1, 7, 'hA,    0, 1, 'hB,    0, 0,     0);
    tbl[8]  = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 7,   0, 1, 1, 7, 'hB,    0, 1, 'hB,    0, 0,     0);
    tbl[9]  = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 0,   0, 1, 0, 0, 'h55,   0, 0, 0,      0, 0,     0);
    tbl[10] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 0,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[11] = v(1, 0, 0, 'h5,   0, 0, 0,      1, 0, 0,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[12] = v(1, 0, 0, 'h100, 0, 0, 0,      0, 3, 0,   0, 1, 0, 0, 0,      1, 0, 0,      0, 0,     0);
    tbl[13] = v(1, 0, 0, 'h7,   1, 9, 'h99,   0, 0, 9,   0, 1, 0, 0, 0,      1, 0, 0,      0, 0,     0);
    tbl[14] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 9,   0, 1, 0, 0, 0,      1, 1, 'h99,   0, 0,     0);
    tbl[15] = v(1, 0, 1, 'h8,   1, 10, 'h77,  0, 0, 9,   0, 0, 0, 0, 0,      0, 1, 'h99,   0, 0,     0);
    tbl[16] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 9,   0, 0, 0, 0, 0,      0, 0, 0,      1, 'h100, 3);
    tbl[17] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 10,  0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[18] = v(1, 0, 1, 'h9,   1, 3, 'h33,   0, 0, 3,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[19] = v(1, 1, 1, 'hA,   1, 4, 'h44,   0, 0, 4,   0, 1, 1, 3, 'h33,   0, 0, 0,      0, 0,     0);
    tbl[20] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 4,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[21] = v(1, 0, 0, 'hB,   1, 1, 'h1,    0, 0, 0,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);
    tbl[22] = v(1, 0, 0, 'hC,   1, 2, 'h2,    0, 0, 0,   0, 1, 1, 1, 'h1,    0, 0, 0,      0, 0,     0);
    tbl[23] = v(1, 0, 0, 'hD,   1, 3, 'h3,    0, 0, 0,   0, 1, 1, 1, 'h1,    0, 0, 0,      0, 0,     0);
    tbl[24] = v(1, 0, 0, 'hE,   1, 4, 'h4,    0, 0, 0,   0, 1, 1, 1, 'h1,    0, 0, 0,      0, 0,     0);
    tbl[25] = v(1, 0, 0, 'hF,   1, 5, 'h5,    0, 0, 5,   1, 1, 1, 1, 'h1,    0, 0, 0,      0, 0,     0);
    tbl[26] = v(0, 0, 0, 0,     0, 0, 0,      0, 0, 5,   1, 1, 1, 1, 'h1,    0, 0, 0,      0, 0,     0);
    tbl[27] = v(1, 0, 1, 'h10,  1, 6, 'h6,    0, 0, 4,   1, 1, 1, 1, 'h1,    0, 1, 'h4,    0, 0,     0);
    tbl[28] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 6,   0, 1, 1, 2, 'h2,    0, 0, 0,      0, 0,     0);
    tbl[29] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 0,   0, 1, 1, 3, 'h3,    0, 0, 0,      0, 0,     0);
    tbl[30] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 0,   0, 1, 1, 4, 'h4,    0, 0, 0,      0, 0,     0);
    tbl[31] = v(0, 0, 1, 0,     0, 0, 0,      0, 0, 0,   0, 0, 0, 0, 0,      0, 0, 0,      0, 0,     0);

    t = '0; t.rst = 1'b1;
    drive(t);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].s);
      #1;
      chk($sformatf("vec[%0d]", i), g4, tbl[i].x);
      @(negedge clk);
    end

    // reset in the middle of a drain
    t = '0; t.rst = 1'b1; drive(t); @(negedge clk);
    t = '0; t.en = 1'b1; t.rd_en = 1'b1; t.rd_addr = 5'd11; t.rd_data = 32'hB1;
    drive(t); @(negedge clk);
    t.rd_addr = 5'd12; t.rd_data = 32'hB2;
    drive(t); @(negedge clk);
    t = '0; t.rdy = 1'b1; t.fwd = 5'd11; drive(t); #1;
    chk("rst_pre_head", {valid4, addr4, data4}, {1'b1, 5'd11, 32'hB1});
    @(negedge clk);
    t = '0; t.rst = 1'b1; t.rdy = 1'b1; t.fwd = 5'd12; drive(t); #1;
    chk("rst_cycle_outputs", {valid4, busy4, rden4, fh4, fd4}, '0);
    @(negedge clk);
    t = '0; t.rdy = 1'b1; t.fwd = 5'd12; drive(t); #1;
    chk("rst_after_outputs", {valid4, busy4, fh4, ev4}, '0);
    @(negedge clk);
    t = '0; t.en = 1'b1; t.rd_en = 1'b1; t.rd_addr = 5'd13; t.rd_data = 32'hC3; t.rdy = 1'b1;
    drive(t); #1;
    chk("rst_empty", valid4, 0);
    @(negedge clk);
    t = '0; t.rdy = 1'b1; t.fwd = 5'd13; drive(t); #1;
    chk("rst_refill_head", {valid4, addr4, data4, fh4, fd4}, {1'b1, 5'd13, 32'hC3, 1'b1, 32'hC3});
    @(negedge clk);

    // pointer wrap on the DEPTH=3 instance: nine entries in order
    t = '0; t.rst = 1'b1; drive(t); @(negedge clk);
    k = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 9; cyc++) begin
      t = '0;
      t.rdy = (cyc >= 4);
      if (k < 9) begin
        t.en = 1'b1; t.rd_en = 1'b1; t.rd_addr = 5'(k + 1); t.rd_data = 32'h300 + 32'(k);
      end
      drive(t); #1;
      if (cyc == 3) chk("wrap_full", busy3, 1);
      if (valid3 && rf_wr_ready) begin
        chk("wrap_order", {addr3, data3}, {5'(got + 1), 32'h300 + 32'(got)});
        got++;
      end
      if (t.en && !busy3) k++;
      @(negedge clk);
    end
    chk("wrap_count", got, 9);

    // randomized run against the reference model
    t = '0; t.rst = 1'b1; drive(t); @(negedge clk);
    m4 = '0; m4.depth = 4'd4;
    m3 = '0; m3.depth = 4'd3;
    for (int n = 0; n < 3000; n++) begin
      t = rnd();
      drive(t); #1;
      chk("rand_d4", o4, m_obs(m4, t));
      chk("rand_d3", o3, m_obs(m3, t));
      @(posedge clk);
      m4 = m_next(m4, t);
      m3 = m_next(m3, t);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pu_wb_buf.md
Name: pu_wb_buf

Overview:
- Parametrised writeback stage with a retire buffer between the DA/WB pipeline register and a shared GPR/HI/LO write port that can refuse writes (valid/ready).
- Queues committed results in order and drains them one per accepted cycle.
- Provides youngest-match forwarding to ID from the buffer.
- Reports precise exceptions at the buffer head and squashes younger buffered work.

Parameters:
- DATA_W, 32, GPR/HI/LO data width
- PC_W, 30, word-address PC width
- GPR_AW, 5, GPR address width
- EXP_W, 4, exception code width (0 = no exception)
- DEPTH, 4, retire buffer entries (>=2, need not be a power of two)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_flush  in  1  drop the input presented this cycle
- wb_busy  out  1  buffer full; upstream must hold
- in_en  in  1  DA/WB register valid
- in_pc  in  PC_W  instruction PC
- in_rd_en  in  1  GPR write request
- in_rd_addr  in  GPR_AW  GPR destination
- in_rd_data  in  DATA_W  GPR data
- in_hi_en  in  1  HI write request
- in_hi_data  in  DATA_W  HI data
- in_lo_en  in  1  LO write request
- in_lo_data  in  DATA_W  LO data
- in_exp  in  EXP_W  exception code
- rf_wr_valid  out  1  head entry write request
- rf_wr_ready  in  1  register-file port accepts this cycle
- rf_pc  out  PC_W  head PC
- rf_rd_en  out  1  head GPR write enable
- rf_rd_addr  out  GPR_AW  head GPR address
- rf_rd_data  out  DATA_W  head GPR data
- rf_hi_en  out  1  head HI write enable
- rf_hi_data  out  DATA_W  head HI data
- rf_lo_en  out  1  head LO write enable
- rf_lo_data  out  DATA_W  head LO data
- exp_valid  out  1  one-cycle exception pulse
- exp_pc  out  PC_W  excepting PC
- exp_code  out  EXP_W  exception code
- fwd_addr  in  GPR_AW  ID lookup address
- fwd_rd_hit  out  1  buffered GPR match
- fwd_rd_data  out  DATA_W  youngest matching GPR data
- fwd_hi_hit  out  1  buffered HI write present
- fwd_hi_data  out  DATA_W  youngest HI data
- fwd_lo_hit  out  1  buffered LO write present
- fwd_lo_data  out  DATA_W  youngest LO data

Behaviour:
- Reset:
  - count, head and tail cleared.
  - wb_busy, rf_wr_valid, exp_valid, exp_pc, exp_code and all fwd hits are 0.
  - Reset mid-drain discards all entries; no rf write is issued in the reset cycle.
- Enqueue:
  - Occurs when in_en & !wb_flush & !wb_busy & !squash & (in_rd_en | in_hi_en | in_lo_en | in_exp != 0).
  - Entries with no write and no exception retire without occupying a slot.
  - in_rd_en is stored as 0 when in_rd_addr == 0.
- wb_busy = (count == DEPTH), derived from registered count. No push is accepted when full, even if the head pops in the same cycle.
- Latency: an input is written into the buffer at the clock edge and is visible on the rf_* outputs at the earliest one cycle later.
- Head handling, with head exp == 0:
  - rf_wr_valid = (count != 0).
  - rf_* outputs are combinational from the head entry.
  - The entry pops when rf_wr_valid & rf_wr_ready.
- Head handling, with head exp != 0 (squash):
  - rf_wr_valid is 0 and no write is issued.
  - Next edge: exp_valid = 1 for exactly one cycle, with exp_pc and exp_code from the head entry.
  - At that same edge, the whole buffer is cleared (head and all younger entries); count = 0, head = tail.
  - Any enqueue in the squash cycle is dropped.
- Pointers advance modulo DEPTH; the increment wraps from DEPTH-1 to 0.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Forwarding:
  - Combinational search over valid entries from youngest to oldest.
  - fwd_rd_hit is set on the youngest entry with rd_en & rd_addr == fwd_addr & exp == 0; fwd_rd_data is that entry's data.
  - fwd_addr == 0 never hits.
  - HI and LO use the youngest entry with the corresponding enable.
  - All data outputs are 0 when there is no hit.
  - The entry popping this cycle still forwards; ID owns the priority between DA forwarding and this buffer.
- wb_flush affects only the input of the current cycle. Buffered entries are committed and are never flushed by wb_flush.

Test Plan:
1. Reset, then push rd_en with addr 5 and data 0x1234 while rf_wr_ready = 1.
   - rf_wr_valid rises one cycle later with addr 5, data 0x1234, then falls.
   - count returns to 0.
2. Hold rf_wr_ready = 0 and push 4 GPR writes with DEPTH = 4.
   - wb_busy = 1 after the 4th push; a 5th push is not accepted.
   - After rf_wr_ready = 1, the four writes drain in order and wb_busy falls.
3. Push addr 7 = 0xA, then addr 7 = 0xB, with rf_wr_ready = 0 and fwd_addr = 7.
   - fwd_rd_hit = 1 and fwd_rd_data = 0xB.
   - With fwd_addr = 0 and a queued write to addr 0: no hit and no rf write.
4. Queue a HI/LO write, then an entry with in_exp = 3 and pc 0x100, then a GPR write.
   - The HI/LO write drains first.
   - exp_valid pulses once with exp_pc 0x100 and exp_code 3.
   - The younger GPR write is never issued.
5. Assert wb_flush with in_en = 1 on a cycle where an entry is draining.
   - The input is not enqueued; the drain completes normally.
6. Fill 2 entries, assert rst for one cycle mid-drain.
   - All outputs go to 0 and the buffer is empty.
   - Pointer wrap is checked by pushing 9 entries through with DEPTH = 3.
